bomb_ram_arbiter: RTL and testbench

Arbitrates the single-port bomb sprite block RAM (address, write-enable, data-in, data-out; one clock) between three requesters: the VGA pixel fetch path, a host/loader port for sprite updates and readback, and an internal clear sequencer that fills the RAM with a constant. It sits between the sprite renderer and the bomb RAM instance, drives every RAM input, and routes read data back to whichever requester issued the read.

---
 rtl/bomb_ram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_bomb_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_ram_arbiter.sv
// Single-port bomb sprite RAM arbiter: pixel fetch > clear sequencer > host port.
// Drives every RAM input and steers returning read data back to its requester.
`timescale 1ns/1ps

module bomb_ram_arbiter #(
  parameter int                ADDR_W     = 10,
  parameter int                DATA_W     = 8,
  parameter int                RD_LAT     = 1,
  parameter logic [DATA_W-1:0] CLR_VAL    = '0,
  parameter int                STARVE_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              pix_rvalid,
  output logic [DATA_W-1:0] pix_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_starved,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0]  STARVE_PRE = CNT_W'(STARVE_MAX - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              done_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              starved_q;
  logic [RD_LAT-1:0] tag_pix;
  logic [RD_LAT-1:0] tag_host;
  logic              grant_pix;
  logic              grant_clr;
  logic              grant_host;

  // Pixel fetch can never wait, so it pre-empts even an active clear.
  always_comb begin
    grant_pix  = 1'b0;
    grant_clr  = 1'b0;
    grant_host = 1'b0;
    if (!rst) begin
      if (pix_req)
        grant_pix = 1'b1;
      else if (state == ST_CLEAR)
        grant_clr = 1'b1;
      else if (host_req)
        grant_host = 1'b1;
    end
  end

  always_comb begin
    ram_addr = last_addr;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (rst) begin
      ram_addr = '0;
    end else if (grant_pix) begin
      ram_addr = pix_addr;
    end else if (grant_clr) begin
      ram_addr = clr_addr;
      ram_we   = 1'b1;
      ram_din  = CLR_VAL;
    end else if (grant_host) begin
      ram_addr = host_addr;
      ram_we   = host_we;
      ram_din  = host_wdata;
    end
  end

  assign host_gnt = grant_host;

  // Idle cycles keep the address bus steady to avoid needless RAM toggling.
  always_ff @(posedge clk) begin
    if (rst)
      last_addr <= '0;
    else
      last_addr <= ram_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      clr_addr <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (clr_start) begin
          state    <= ST_CLEAR;
          clr_addr <= '0;
        end
      end else if (grant_clr) begin
        if (clr_addr == LAST_ADDR) begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
        end
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  assign clr_busy = (state == ST_CLEAR);
  assign clr_done = done_q;

  // Tags travel alongside the RAM pipeline so each read word finds its owner.
  generate
    if (RD_LAT == 1) begin : g_tag_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_pix  <= '0;
          tag_host <= '0;
        end else begin
          tag_pix  <= grant_pix;
          tag_host <= grant_host & ~host_we;
        end
      end
    end else begin : g_tag_latn
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_pix  <= '0;
          tag_host <= '0;
        end else begin
          tag_pix  <= {tag_pix[RD_LAT-2:0], grant_pix};
          tag_host <= {tag_host[RD_LAT-2:0], grant_host & ~host_we};
        end
      end
    end
  endgenerate

  assign pix_rvalid  = tag_pix[RD_LAT-1];
  assign host_rvalid = tag_host[RD_LAT-1];
  assign pix_rdata   = ram_dout;
  assign host_rdata  = ram_dout;

  // The starvation flag is status only; it never changes who gets the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      starved_q <= 1'b0;
    end else if (grant_host) begin
      wait_cnt  <= '0;
      starved_q <= 1'b0;
    end else if (host_req) begin
      if (wait_cnt < STARVE_LIM)
        wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt >= STARVE_PRE)
        starved_q <= 1'b1;
    end
  end

  assign host_starved = starved_q;

endmodule

// File: tb/tb_bomb_ram_arbiter.sv
// Self-checking bench for bomb_ram_arbiter: cycle-level reference model, RAM model
// and read-return scoreboard, plus directed latency checks from the test plan.
`timescale 1ns/1ps

module tb_bomb_ram_arbiter;

  localparam int                ADDR_W     = 10;
  localparam int                DATA_W     = 8;
  localparam int                RD_LAT     = 2;
  localparam int                STARVE_MAX = 8;
  localparam logic [DATA_W-1:0] CLR_VAL    = 8'hC3;
  localparam int                DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_req;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_rvalid;
  logic [DATA_W-1:0] pix_rdata;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              host_starved;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bomb_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
    .CLR_VAL(CLR_VAL), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_req(pix_req), .pix_addr(pix_addr), .pix_rvalid(pix_rvalid), .pix_rdata(pix_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_starved(host_starved),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-first block RAM with RD_LAT cycles of read latency
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      rd_pipe[0]    <= ram_din;
    end else begin
      rd_pipe[0] <= mem[ram_addr];
    end
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign ram_dout = rd_pipe[RD_LAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle
  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } ret_t;

  ret_t              pix_q[$];
  ret_t              host_q[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              armed      = 1'b0;
  logic              m_clearing = 1'b0;
  logic [ADDR_W-1:0] m_clr_addr = '0;
  logic              m_done     = 1'b0;
  int                m_cnt      = 0;
  logic              m_starved  = 1'b0;
  logic [ADDR_W-1:0] m_last     = '0;

  always @(negedge clk) begin
    logic              e_pix, e_clr, e_host, e_we;
    logic [ADDR_W-1:0] e_addr;
    ret_t              r;
    e_pix  = !rst && pix_req;
    e_clr  = !rst && !pix_req && m_clearing;
    e_host = !rst && !pix_req && !m_clearing && host_req;
    e_we   = e_clr || (e_host && host_we);
    if (rst)        e_addr = '0;
    else if (e_pix) e_addr = pix_addr;
    else if (e_clr) e_addr = m_clr_addr;
    else if (e_host) e_addr = host_addr;
    else            e_addr = m_last;

    if (armed) begin
      checkOutput("host_gnt", host_gnt, e_host);
      checkOutput("ram_we", ram_we, e_we);
      checkOutput("ram_addr", ram_addr, e_addr);
      if (e_we) checkOutput("ram_din", ram_din, e_clr ? CLR_VAL : host_wdata);
      checkOutput("clr_busy", clr_busy, m_clearing);
      checkOutput("clr_done", clr_done, m_done);
      checkOutput("host_starved", host_starved, m_starved);
      if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
        checkOutput("pix_rvalid", pix_rvalid, 1);
        checkOutput("pix_rdata", pix_rdata, pix_q[0].data);
        void'(pix_q.pop_front());
      end else begin
        checkOutput("pix_rvalid", pix_rvalid, 0);
      end
      if (host_q.size() > 0 && host_q[0].due == cyc) begin
        checkOutput("host_rvalid", host_rvalid, 1);
        checkOutput("host_rdata", host_rdata, host_q[0].data);
        void'(host_q.pop_front());
      end else begin
        checkOutput("host_rvalid", host_rvalid, 0);
      end
    end

    if (rst) begin
      armed      = 1'b1;
      m_clearing = 1'b0;
      m_clr_addr = '0;
      m_done     = 1'b0;
      m_cnt      = 0;
      m_starved  = 1'b0;
      m_last     = '0;
      while (pix_q.size() > 0 && pix_q[pix_q.size()-1].due > cyc) void'(pix_q.pop_back());
      while (host_q.size() > 0 && host_q[host_q.size()-1].due > cyc) void'(host_q.pop_back());
    end else if (armed) begin
      if (e_pix) begin
        r.due = cyc + RD_LAT; r.data = ref_mem[pix_addr]; pix_q.push_back(r);
      end
      if (e_host && !host_we) begin
        r.due = cyc + RD_LAT; r.data = ref_mem[host_addr]; host_q.push_back(r);
      end
      if (e_host && host_we) ref_mem[host_addr] = host_wdata;
      m_last = e_addr;
      m_done = 1'b0;
      if (m_clearing) begin
        if (e_clr) begin
          ref_mem[m_clr_addr] = CLR_VAL;
          if (m_clr_addr == {ADDR_W{1'b1}}) begin
            m_clearing = 1'b0;
            m_done     = 1'b1;
          end
          m_clr_addr = m_clr_addr + 1'b1;
        end
      end else if (clr_start) begin
        m_clearing = 1'b1;
        m_clr_addr = '0;
      end
      if (e_host) begin
        m_cnt     = 0;
        m_starved = 1'b0;
      end else if (host_req) begin
        if (m_cnt < STARVE_MAX) m_cnt++;
        if (m_cnt >= STARVE_MAX) m_starved = 1'b1;
      end
    end
  end

  // Event timestamps for the directed latency checks
  int                busy_cnt = 0, done_cnt = 0, done_cyc = 0;
  int                starve_rise_cyc = 0, starve_fall_cyc = 0;
  int                host_rv_cyc = 0, pix_rv_cyc = 0, pix_rv_cnt = 0;
  logic              prev_starved = 1'b0;
  logic [DATA_W-1:0] last_host_rdata = '0, last_pix_rdata = '0;

  always @(negedge clk) begin
    if (clr_busy === 1'b1) busy_cnt++;
    if (clr_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (host_starved === 1'b1 && !prev_starved) starve_rise_cyc = cyc;
    if (host_starved === 1'b0 && prev_starved) starve_fall_cyc = cyc;
    prev_starved = (host_starved === 1'b1);
    if (host_rvalid === 1'b1) begin host_rv_cyc = cyc; last_host_rdata = host_rdata; end
    if (pix_rvalid === 1'b1) begin pix_rv_cyc = cyc; pix_rv_cnt++; last_pix_rdata = pix_rdata; end
  end

  task automatic applyStimulus(input logic p, input logic [ADDR_W-1:0] pa,
                               input logic hr, input logic hw, input logic [ADDR_W-1:0] ha,
                               input logic [DATA_W-1:0] hd, input logic cs, input logic r);
    pix_req = p; pix_addr = pa;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    clr_start = cs; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic hostWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    applyStimulus(0, '0, 1, 1, a, d, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, b0, d0, p0, n0;
    applyStimulus(0, '0, 0, 0, '0, '0, 0, 1);
    applyStimulus(1, 10'd5, 1, 1, 10'd9, 8'h12, 1, 1);
    idle(1);
    checkOutput("reset_busy", clr_busy, 0);
    checkOutput("reset_starved", host_starved, 0);

    $display("[TB] clear with host write in start cycle");
    t0 = cyc; b0 = busy_cnt;
    applyStimulus(0, '0, 1, 1, 10'h3FF, 8'h77, 1, 0);
    idle(1030);
    checkOutput("clr_done_lat", done_cyc - t0, 1025);
    checkOutput("clr_busy_len", busy_cnt - b0, 1024);

    $display("[TB] pixel stream");
    hostWrite(10'd5, 8'h11); hostWrite(10'd6, 8'h22); hostWrite(10'd7, 8'h33);
    p0 = cyc; b0 = pix_rv_cnt;
    applyStimulus(1, 10'd5, 0, 0, '0, '0, 0, 0);
    applyStimulus(1, 10'd6, 0, 0, '0, '0, 0, 0);
    applyStimulus(1, 10'd7, 0, 0, '0, '0, 0, 0);
    idle(RD_LAT + 1);
    checkOutput("pix_stream_cnt", pix_rv_cnt - b0, 3);
    checkOutput("pix_stream_last", pix_rv_cyc - p0, 2 + RD_LAT);
    checkOutput("pix_stream_data", last_pix_rdata, 8'h33);

    $display("[TB] host held off by pixels");
    for (int i = 0; i < 4; i++) applyStimulus(1, 10'd20, 1, 1, 10'd9, 8'hAB, 0, 0);
    applyStimulus(0, '0, 1, 1, 10'd9, 8'hAB, 0, 0);
    t0 = cyc;
    applyStimulus(0, '0, 1, 0, 10'd9, '0, 0, 0);
    idle(RD_LAT + 1);
    checkOutput("host_rd9_lat", host_rv_cyc - t0, RD_LAT);
    checkOutput("host_rd9_data", last_host_rdata, 8'hAB);

    $display("[TB] write then read same address");
    hostWrite(10'd12, 8'h5E);
    applyStimulus(1, 10'd12, 0, 0, '0, '0, 0, 0);
    idle(RD_LAT + 1);
    checkOutput("raw_data", last_pix_rdata, 8'h5E);

    $display("[TB] starvation");
    t0 = cyc;
    for (int i = 0; i < 12; i++) applyStimulus(1, 10'(33 + i), 1, 0, 10'd5, '0, 0, 0);
    applyStimulus(0, '0, 1, 0, 10'd5, '0, 0, 0);
    idle(RD_LAT + 2);
    checkOutput("starve_rise", starve_rise_cyc - t0, 8);
    checkOutput("starve_fall", starve_fall_cyc - t0, 13);

    $display("[TB] clear with pixel traffic and waiting host");
    t0 = cyc; b0 = busy_cnt; p0 = pix_rv_cnt;
    for (int k = 0; k < 1040; k++)
      applyStimulus(k >= 500 && k < 510, 10'($urandom_range(0, DEPTH - 1)),
                    k >= 100 && k <= 1035, 0, 10'd6, '0, k == 0, 0);
    idle(RD_LAT + 1);
    checkOutput("clr_done_lat_pix", done_cyc - t0, 1035);
    checkOutput("clr_busy_len_pix", busy_cnt - b0, 1034);
    checkOutput("clr_pix_returns", pix_rv_cnt - p0, 10);

    $display("[TB] reset mid-clear");
    t0 = cyc;
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 0);
    idle(300);
    checkOutput("clr_addr_300", ram_addr, 10'd300);
    d0 = done_cnt;
    applyStimulus(0, '0, 0, 0, '0, '0, 0, 1);
    idle(5);
    checkOutput("rst_no_done", done_cnt - d0, 0);
    checkOutput("rst_busy", clr_busy, 0);
    t0 = cyc;
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 0);
    checkOutput("restart_we", ram_we, 1);
    checkOutput("restart_addr0", ram_addr, 10'd0);
    idle(1030);
    checkOutput("restart_done_lat", done_cyc - t0, 1025);

    $display("[TB] latency-2 interleave");
    hostWrite(10'd3, 8'h3C); hostWrite(10'd4, 8'h4D);
    n0 = cyc;
    applyStimulus(0, '0, 1, 0, 10'd3, '0, 0, 0);
    applyStimulus(1, 10'd4, 0, 0, '0, '0, 0, 0);
    idle(4);
    checkOutput("il_host_lat", host_rv_cyc - n0, 2);
    checkOutput("il_host_data", last_host_rdata, 8'h3C);
    checkOutput("il_pix_lat", pix_rv_cyc - n0, 3);
    checkOutput("il_pix_data", last_pix_rdata, 8'h4D);

    idle(2);
    checkOutput("sb_pix_empty", pix_q.size(), 0);
    checkOutput("sb_host_empty", host_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
